fft_mem_ctrl: RTL and testbench
===============================

// Module: fft_mem_ctrl
// PURPOSE
//  Sequencer for the in-place radix-2 DIT memory-based FFT. Sits directly upstream of the butterfly datapath.
//  Each butterfly: reads operand pair A/B from dual-port BRAM, drives registered operands out_REG_A/out_REG_B
//  and twiddle ROM address, then writes butterfly results back to the same addresses.
//  Input data is already bit-reversed in BRAM; result is natural order. Word = {im[31:16], re[15:0]}.
// PARAMETERS
//  N_POINT  16  FFT length, power of 2, >= 4
//  LOG2N    4   log2(N_POINT); number of stages
//  DATA_W   32  packed complex word width
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        synchronous active-high reset
//  start        in   1        begin transform; sampled only in IDLE
//  busy         out  1        high from cycle after accepted start until DONE
//  done         out  1        one-cycle pulse, transform finished
//  en_bram      out  1        BRAM enable, both ports
//  we_bram      out  1        write enable, both ports
//  addr_a       out  LOG2N    BRAM port A address
//  addr_b       out  LOG2N    BRAM port B address
//  data_rd_a    in   DATA_W   BRAM port A read data, 1-cycle latency
//  data_rd_b    in   DATA_W   BRAM port B read data, 1-cycle latency
//  data_wr_a    out  DATA_W   port A write data (= in_FFT0)
//  data_wr_b    out  DATA_W   port B write data (= in_FFT1)
//  addr_ROM     out  LOG2N-1  twiddle ROM address; ROM registered, 1-cycle latency
//  out_REG_A    out  DATA_W   butterfly upper operand register
//  out_REG_B    out  DATA_W   butterfly lower operand register (multiplied by twiddle)
//  in_FFT0      in   DATA_W   butterfly result A + W*B (combinational from out_REG_*)
//  in_FFT1      in   DATA_W   butterfly result A - W*B
// BEHAVIOUR
//  - Reset: state IDLE; busy, done, en_bram, we_bram = 0; addr_*, addr_ROM, out_REG_* = 0; counters 0.
//  - FSM: IDLE -> RD (on start) -> LAT -> WR -> RD (next bfly) or DONE (last bfly of last stage) -> IDLE.
//  - Counters: stage s in 0..LOG2N-1, bfly j in 0..N_POINT/2-1; j advances in WR, wraps to 0 with s+1.
//  - Addresses: span=1<<s; k=j&(span-1); addr_a=((j>>s)<<(s+1))|k; addr_b=addr_a+span;
//    addr_ROM = k<<(LOG2N-1-s). All three are registered, set on RD entry, held through LAT and WR.
//  - RD: en_bram=1, we_bram=0. LAT: data_rd_* valid; captured into out_REG_A/B at end of LAT.
//    ROM data valid from LAT, stable through WR.
//  - WR: en_bram=1, we_bram=1, data_wr_a=in_FFT0, data_wr_b=in_FFT1 to addr_a/addr_b.
//  - Latency: 3 cycles per butterfly; start-to-done = 3*(N_POINT/2)*LOG2N + 1 cycles (97 for N=16).
//  - Stage hazard: no overlap; the next stage's RD follows the last WR, so the read sees written data
//    (write-first or read-first BRAM both correct).
//  - DONE: done=1, busy=0 for one cycle; en_bram=0. start in DONE or any non-IDLE state is ignored.
//  - rst mid-transform: IDLE next edge, we_bram=0 immediately; BRAM contents undefined. rst beats start.
//  - No arithmetic here; scaling/overflow owned by the butterfly.
// STRUCTURE
//  - fft_pkg: N_POINT, LOG2N, DATA_W, state encoding (IDLE/RD/LAT/WR/DONE), bfly_addr_t / tw_addr_t widths.
//  - Sub-module fft_addr_gen: combinational (s, j) -> addr_a, addr_b, addr_ROM. Registered in the parent.
// TESTING
//  - Reset then idle: all outputs 0 for 10 cycles; start with rst=1 -> stays IDLE.
//  - N=16 address trace: s0 j0 -> a=0 b=1 tw=0; s1 j1 -> a=1 b=3 tw=4; s2 j5 -> a=9 b=13 tw=2;
//    s3 j5 -> a=5 b=13 tw=5.
//  - Timing: start at cycle 0 -> busy from 1; first we_bram at cycle 3; done pulse at cycle 97; 32 writes total.
//  - Full transform with BRAM + ROM + butterfly models: impulse x[0]=0x0000_1000 -> every bin equals reference-model
//    output; a bit-reversed single-tone input -> energy only in the tone bin, matching the C model bit-exactly.
//  - start pulsed every cycle during busy -> no restart, single done; start in DONE cycle ignored.
//  - rst asserted in a WR cycle of stage 2 -> we_bram=0 next cycle, IDLE; subsequent start runs a full clean transform.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared sizes, types and FSM encoding for the in-place radix-2 DIT FFT memory sequencer.
package fft_pkg;

    localparam int unsigned N_POINT = 16;
    localparam int unsigned LOG2N   = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned N_BFLY  = N_POINT / 2;
    localparam int unsigned STAGE_W = (LOG2N > 2) ? $clog2(LOG2N) : 1;

    typedef logic [LOG2N-1:0]   bfly_addr_t;
    typedef logic [LOG2N-2:0]   tw_addr_t;
    typedef logic [LOG2N-2:0]   bfly_idx_t;
    typedef logic [STAGE_W-1:0] stage_t;
    typedef logic [DATA_W-1:0]  data_t;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StLat,
        StWr,
        StDone
    } state_t;

    localparam stage_t    LAST_STAGE = stage_t'(LOG2N - 1);
    localparam bfly_idx_t LAST_BFLY  = bfly_idx_t'(N_BFLY - 1);

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address generator: (stage, butterfly index) -> BRAM pair and twiddle address.
module fft_addr_gen
    import fft_pkg::*;
(
    input  logic [STAGE_W-1:0] i_stage,
    input  logic [LOG2N-2:0]   i_bfly,
    output logic [LOG2N-1:0]   o_addr_a,
    output logic [LOG2N-1:0]   o_addr_b,
    output logic [LOG2N-2:0]   o_addr_rom
);

    bfly_addr_t w_j;
    bfly_addr_t w_span;
    bfly_addr_t w_k;
    bfly_addr_t w_base;
    tw_addr_t   w_k_tw;

    always_comb begin
        w_j    = bfly_addr_t'(i_bfly);
        w_span = bfly_addr_t'(1) << i_stage;
        w_k    = w_j & (w_span - bfly_addr_t'(1));
        // Group index moves up one bit to leave room for the span bit of the pair.
        w_base = (w_j >> i_stage) << (i_stage + 1);
        // k < span <= N/2, so it always fits the narrower twiddle index.
        w_k_tw = tw_addr_t'(w_k);
    end

    assign o_addr_a   = w_base | w_k;
    assign o_addr_b   = o_addr_a + w_span;
    assign o_addr_rom = w_k_tw << (LOG2N - 1 - i_stage);

endmodule

// File: rtl/fft_mem_ctrl.sv
// Sequencer for an in-place radix-2 DIT FFT: read pair, latch operands, write butterfly results back.
module fft_mem_ctrl
    import fft_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_en_bram,
    output logic                o_we_bram,
    output logic [LOG2N-1:0]    o_addr_a,
    output logic [LOG2N-1:0]    o_addr_b,
    input  logic [DATA_W-1:0]   i_data_rd_a,
    input  logic [DATA_W-1:0]   i_data_rd_b,
    output logic [DATA_W-1:0]   o_data_wr_a,
    output logic [DATA_W-1:0]   o_data_wr_b,
    output logic [LOG2N-2:0]    o_addr_rom,
    output logic [DATA_W-1:0]   o_out_reg_a,
    output logic [DATA_W-1:0]   o_out_reg_b,
    input  logic [DATA_W-1:0]   i_in_fft0,
    input  logic [DATA_W-1:0]   i_in_fft1
);

    state_t     r_state;
    state_t     w_state_d;
    stage_t     r_stage;
    stage_t     w_stage_d;
    bfly_idx_t  r_bfly;
    bfly_idx_t  w_bfly_d;
    logic       w_last;

    bfly_addr_t r_addr_a;
    bfly_addr_t r_addr_b;
    tw_addr_t   r_addr_rom;
    data_t      r_reg_a;
    data_t      r_reg_b;

    bfly_addr_t w_gen_a;
    bfly_addr_t w_gen_b;
    tw_addr_t   w_gen_rom;

    assign w_last = (r_stage == LAST_STAGE) && (r_bfly == LAST_BFLY);

    // Addresses are generated from the next-state counters so they are ready on RD entry.
    fft_addr_gen u_addr_gen (
        .i_stage    (w_stage_d),
        .i_bfly     (w_bfly_d),
        .o_addr_a   (w_gen_a),
        .o_addr_b   (w_gen_b),
        .o_addr_rom (w_gen_rom)
    );

    always_comb begin
        w_state_d = r_state;
        w_stage_d = r_stage;
        w_bfly_d  = r_bfly;
        unique case (r_state)
            StIdle: begin
                w_stage_d = '0;
                w_bfly_d  = '0;
                if (i_start) begin
                    w_state_d = StRd;
                end
            end
            StRd: begin
                w_state_d = StLat;
            end
            StLat: begin
                w_state_d = StWr;
            end
            StWr: begin
                if (w_last) begin
                    w_state_d = StDone;
                    w_stage_d = '0;
                    w_bfly_d  = '0;
                end else begin
                    w_state_d = StRd;
                    if (r_bfly == LAST_BFLY) begin
                        w_bfly_d  = '0;
                        w_stage_d = r_stage + 1'b1;
                    end else begin
                        w_bfly_d  = r_bfly + 1'b1;
                    end
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_stage    <= '0;
            r_bfly     <= '0;
            r_addr_a   <= '0;
            r_addr_b   <= '0;
            r_addr_rom <= '0;
            r_reg_a    <= '0;
            r_reg_b    <= '0;
        end else begin
            r_state <= w_state_d;
            r_stage <= w_stage_d;
            r_bfly  <= w_bfly_d;
            if (w_state_d == StRd) begin
                r_addr_a   <= w_gen_a;
                r_addr_b   <= w_gen_b;
                r_addr_rom <= w_gen_rom;
            end
            if (r_state == StLat) begin
                r_reg_a <= i_data_rd_a;
                r_reg_b <= i_data_rd_b;
            end
        end
    end

    always_comb begin
        o_busy    = (r_state == StRd) || (r_state == StLat) || (r_state == StWr);
        o_done    = (r_state == StDone);
        o_en_bram = (r_state == StRd) || (r_state == StWr);
        // Reset kills a pending write in the same cycle, not one edge later.
        o_we_bram = (r_state == StWr) && !i_rst;
    end

    assign o_addr_a    = r_addr_a;
    assign o_addr_b    = r_addr_b;
    assign o_addr_rom  = r_addr_rom;
    assign o_out_reg_a = r_reg_a;
    assign o_out_reg_b = r_reg_b;
    assign o_data_wr_a = i_in_fft0;
    assign o_data_wr_b = i_in_fft1;

    a_we_needs_en: assert property (@(posedge i_clk) disable iff (i_rst) o_we_bram |-> o_en_bram);
    a_done_not_busy: assert property (@(posedge i_clk) disable iff (i_rst) o_done |-> !o_busy);

endmodule

// File: tb/tb_fft_mem_ctrl.sv
// Bench for fft_mem_ctrl: BRAM, twiddle ROM and butterfly models with a write/done scoreboard.
module tb_fft_mem_ctrl;
    import fft_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, en, we;
    logic [3:0]  addr_a, addr_b;
    logic [2:0]  addr_rom;
    logic [31:0] rd_a, rd_b, wr_a, wr_b, reg_a, reg_b, fft0, fft1;

    always #5 clk = ~clk;

    fft_mem_ctrl dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .o_busy      (busy),
        .o_done      (done),
        .o_en_bram   (en),
        .o_we_bram   (we),
        .o_addr_a    (addr_a),
        .o_addr_b    (addr_b),
        .i_data_rd_a (rd_a),
        .i_data_rd_b (rd_b),
        .o_data_wr_a (wr_a),
        .o_data_wr_b (wr_b),
        .o_addr_rom  (addr_rom),
        .o_out_reg_a (reg_a),
        .o_out_reg_b (reg_b),
        .i_in_fft0   (fft0),
        .i_in_fft1   (fft1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_start  = 0;
    int wr_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // BRAM model: read-first, 1-cycle latency, with a bench-side load port.
    logic [31:0] mem [16];
    logic        ld_en = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;

    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (en) begin
            if (we) begin
                mem[addr_a] <= wr_a;
                mem[addr_b] <= wr_b;
            end
            rd_a <= mem[addr_a];
            rd_b <= mem[addr_b];
        end
    end

    // Q14 twiddles W^k = cos(2pi k/16) - j sin(2pi k/16), registered ROM.
    int rom_re [8] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137};
    int rom_im [8] = '{0, -6270, -11585, -15137, -16384, -15137, -11585, -6270};
    int tw_re = 0;
    int tw_im = 0;

    always @(posedge clk) begin
        tw_re <= rom_re[addr_rom];
        tw_im <= rom_im[addr_rom];
    end

    int ar, ai, br, bi, pr, pim;
    always_comb begin
        ar   = int'($signed(reg_a[15:0]));
        ai   = int'($signed(reg_a[31:16]));
        br   = int'($signed(reg_b[15:0]));
        bi   = int'($signed(reg_b[31:16]));
        pr   = (br * tw_re - bi * tw_im) >>> 14;
        pim  = (br * tw_im + bi * tw_re) >>> 14;
        fft0 = {16'(ai + pim), 16'(ar + pr)};
        fft1 = {16'(ai - pim), 16'(ar - pr)};
    end

    typedef struct {
        int         rel;
        int         idx;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] tw;
    } wr_exp_t;

    wr_exp_t wq[$];
    int      dq[$];
    wr_exp_t mon_e;

    int hand_idx [4] = '{0, 9, 21, 29};
    int hand_a   [4] = '{0, 1, 9, 5};
    int hand_b   [4] = '{1, 3, 13, 13};
    int hand_tw  [4] = '{0, 4, 2, 5};

    // Expected write order: stage, then group, then offset within group.
    task automatic push_run();
        int idx = 0;
        for (int s = 0; s < 4; s++) begin
            int span = 1 << s;
            for (int g = 0; g < 16 / (2 * span); g++) begin
                for (int k = 0; k < span; k++) begin
                    wr_exp_t e;
                    e.rel = 3 + 3 * idx;
                    e.idx = idx;
                    e.a   = 4'(g * 2 * span + k);
                    e.b   = 4'(g * 2 * span + k + span);
                    e.tw  = 3'(k * 8 / span);
                    wq.push_back(e);
                    idx++;
                end
            end
        end
        dq.push_back(97);
    endtask

    always @(negedge clk) begin
        if (we) begin
            wr_count++;
            if (wq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got write to a=%0d b=%0d required none", addr_a, addr_b);
            end else begin
                mon_e = wq.pop_front();
                check("wr_cycle", 64'(cyc - t_start), 64'(mon_e.rel));
                check("wr_addr_a", addr_a, mon_e.a);
                check("wr_addr_b", addr_b, mon_e.b);
                check("wr_addr_rom", addr_rom, mon_e.tw);
                check("wr_en", en, 1'b1);
                check("reg_a_capture", reg_a, mem[mon_e.a]);
                check("reg_b_capture", reg_b, mem[mon_e.b]);
                check("wr_data", {wr_a, wr_b}, {fft0, fft1});
                for (int h = 0; h < 4; h++) begin
                    if (mon_e.idx == hand_idx[h]) begin
                        check("hand_trace", {addr_a, addr_b, addr_rom},
                              {4'(hand_a[h]), 4'(hand_b[h]), 3'(hand_tw[h])});
                    end
                end
            end
        end
        if (done) begin
            if (dq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done at rel %0d required none", cyc - t_start);
            end else begin
                check("done_cycle", 64'(cyc - t_start), 64'(dq.pop_front()));
                check("done_busy_low", {busy, en}, 2'b00);
            end
        end
    end

    logic [31:0] init_v [16];
    logic [31:0] exp_v  [16];

    task automatic load_mem();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = 4'(i);
            ld_data = init_v[i];
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic check_bins(input string name);
        for (int i = 0; i < 16; i++) begin
            check(name, mem[i], exp_v[i]);
        end
    endtask

    // hold=1 keeps start high through busy and the DONE cycle.
    task automatic run_clean(input bit hold);
        int n;
        push_run();
        wr_count = 0;
        @(negedge clk);
        start   = 1'b1;
        t_start = cyc;
        @(negedge clk);
        if (!hold) start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done in 200 cycles required done at rel 97");
        end
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_restart", {busy, done, we}, 3'b000);
        end
        check("write_total", 64'(wr_count), 64'd32);
        check("queues_drained", 64'(wq.size() + dq.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_beats_start", {busy, done, en, we}, 4'b0000);
        end
        start = 1'b0;
        rst   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ctrl", {busy, done, en, we, addr_a, addr_b, addr_rom}, 15'd0);
            check("idle_regs", {reg_a, reg_b}, 64'd0);
        end

        // Impulse: every bin equals x[0]; start held high throughout.
        for (int i = 0; i < 16; i++) begin
            init_v[i] = (i == 0) ? 32'h0000_1000 : 32'h0;
            exp_v[i]  = 32'h0000_1000;
        end
        load_mem();
        run_clean(1'b1);
        check_bins("impulse_bin");

        // DC input of 256: all energy in bin 0.
        for (int i = 0; i < 16; i++) begin
            init_v[i] = 32'h0000_0100;
            exp_v[i]  = (i == 0) ? 32'h0000_1000 : 32'h0;
        end
        load_mem();
        run_clean(1'b0);
        check_bins("dc_bin");

        // (-1)^n * 256, bit-reversed: first half +256, second half -256; energy only in bin 8.
        for (int i = 0; i < 16; i++) begin
            init_v[i] = (i < 8) ? 32'h0000_0100 : 32'h0000_FF00;
            exp_v[i]  = (i == 8) ? 32'h0000_1000 : 32'h0;
        end
        load_mem();
        run_clean(1'b0);
        check_bins("tone8_bin");

        // Abort in the WR cycle of butterfly 18 (stage 2), then a clean DC transform.
        push_run();
        wr_count = 0;
        @(negedge clk);
        start   = 1'b1;
        t_start = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (56) @(negedge clk);
        #1;
        check("abort_in_wr", we, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_we_immediate", we, 1'b0);
        @(negedge clk);
        check("abort_idle", {busy, done, en, we}, 4'b0000);
        rst = 1'b0;
        wq.delete();
        dq.delete();
        for (int i = 0; i < 16; i++) begin
            init_v[i] = 32'h0000_0100;
            exp_v[i]  = (i == 0) ? 32'h0000_1000 : 32'h0;
        end
        load_mem();
        run_clean(1'b0);
        check_bins("post_abort_bin");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
